// File: rtl/rsa_op_controller.sv
// Job sequencer for the dataPath modular-exponentiation engine: latches operands on start,
// pulses the engine through reset/run, guards the run with a cycle timeout and registers the result.
module rsa_op_controller #(
  parameter int WordSize   = 32,
  parameter int RST_CYCLES = 2,
  parameter int MAX_CYCLES = 4096
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic                mode,
  input  logic [WordSize-1:0] text_in,
  input  logic [WordSize-1:0] pub_key,
  input  logic [WordSize-1:0] priv_key,
  input  logic [WordSize-1:0] mod_in,
  output logic                busy,
  output logic                done,
  output logic                timeout_err,
  output logic [WordSize-1:0] result,
  output logic [WordSize-1:0] dp_input_text,
  output logic [WordSize-1:0] dp_key,
  output logic [WordSize-1:0] dp_mod,
  output logic                dp_load,
  output logic                dp_running,
  output logic                dp_divide,
  input  logic                dp_over,
  input  logic [WordSize-1:0] dp_output_text
);

  localparam int RunW = $clog2(MAX_CYCLES + 1);
  localparam int SetW = $clog2(RST_CYCLES + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SETUP   = 3'd1;
  localparam logic [2:0] S_RUN     = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;
  localparam logic [2:0] S_ABORT   = 3'd5;

  localparam logic [RunW-1:0] RUN_LAST   = RunW'(MAX_CYCLES - 1);
  localparam logic [SetW-1:0] SETUP_LAST = SetW'(RST_CYCLES - 1);

  logic [2:0]          state_q, state_d;
  logic [SetW-1:0]     set_cnt_q, set_cnt_d;
  logic [RunW-1:0]     run_cnt_q, run_cnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                timeout_err_q, timeout_err_d;
  logic [WordSize-1:0] result_q, result_d;
  logic [WordSize-1:0] text_q, text_d;
  logic [WordSize-1:0] key_q, key_d;
  logic [WordSize-1:0] mod_q, mod_d;
  logic                load_q, load_d;
  logic                running_q, running_d;
  logic                divide_q, divide_d;

  // Next-state, counters, operand latch and result capture.
  always_comb begin
    state_d       = state_q;
    set_cnt_d     = set_cnt_q;
    run_cnt_d     = run_cnt_q;
    timeout_err_d = timeout_err_q;
    result_d      = result_q;
    text_d        = text_q;
    key_d         = key_q;
    mod_d         = mod_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          text_d        = text_in;
          mod_d         = mod_in;
          key_d         = mode ? priv_key : pub_key;
          timeout_err_d = 1'b0;
          set_cnt_d     = '0;
          state_d       = S_SETUP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETUP: begin
        if (abort) begin
          state_d = S_ABORT;
        end else if (set_cnt_q == SETUP_LAST) begin
          run_cnt_d = '0;
          state_d   = S_RUN;
        end else begin
          set_cnt_d = set_cnt_q + SetW'(1);
        end
      end
      S_RUN: begin
        run_cnt_d = run_cnt_q + RunW'(1);
        // The first RUN cycle sees the engine just leaving reset, so its over flag is not trusted.
        if (abort) begin
          state_d = S_ABORT;
        end else if (dp_over && (run_cnt_q != '0)) begin
          state_d = S_CAPTURE;
        end else if (run_cnt_q == RUN_LAST) begin
          timeout_err_d = 1'b1;
          result_d      = '0;
          state_d       = S_DONE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_CAPTURE: begin
        result_d = dp_output_text;
        state_d  = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      S_ABORT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs decoded from the next state so they register alongside it.
  always_comb begin
    busy_d    = 1'b0;
    done_d    = 1'b0;
    load_d    = 1'b0;
    running_d = 1'b0;
    divide_d  = 1'b1;
    case (state_d)
      S_IDLE: begin
        divide_d = 1'b1;
      end
      S_SETUP: begin
        busy_d = 1'b1;
        load_d = 1'b1;
      end
      S_RUN: begin
        busy_d    = 1'b1;
        load_d    = 1'b1;
        running_d = 1'b1;
        divide_d  = 1'b0;
      end
      S_CAPTURE: begin
        busy_d   = 1'b1;
        load_d   = 1'b1;
        divide_d = 1'b0;
      end
      S_DONE: begin
        done_d = 1'b1;
      end
      S_ABORT: begin
        busy_d = 1'b1;
      end
      default: begin
        divide_d = 1'b1;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      set_cnt_q     <= '0;
      run_cnt_q     <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      result_q      <= '0;
      text_q        <= '0;
      key_q         <= '0;
      mod_q         <= '0;
      load_q        <= 1'b0;
      running_q     <= 1'b0;
      divide_q      <= 1'b1;
    end else begin
      state_q       <= state_d;
      set_cnt_q     <= set_cnt_d;
      run_cnt_q     <= run_cnt_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      timeout_err_q <= timeout_err_d;
      result_q      <= result_d;
      text_q        <= text_d;
      key_q         <= key_d;
      mod_q         <= mod_d;
      load_q        <= load_d;
      running_q     <= running_d;
      divide_q      <= divide_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign timeout_err   = timeout_err_q;
  assign result        = result_q;
  assign dp_input_text = text_q;
  assign dp_key        = key_q;
  assign dp_mod        = mod_q;
  assign dp_load       = load_q;
  assign dp_running    = running_q;
  assign dp_divide     = divide_q;

endmodule
